// File: rtl/io_map_pkg.sv
// ============================================================================
//  Module      : io_map_pkg
//  Description : I/O address map and word width, shared with the memory wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_map_pkg;
    localparam int          IO_WORD_W   = 16;
    localparam logic [15:0] IO_OUT_ADDR = 16'h3FFC;
    localparam logic [15:0] IO_IN_ADDR  = 16'h3FFE;
    localparam logic [15:0] IO_ACK_ADDR = 16'h3FFA;
endpackage

`default_nettype wire

// File: rtl/io_sync_fifo.sv
// ============================================================================
//  Module      : io_sync_fifo
//  Description : Synchronous FIFO with wrap-bit pointers; head word zeroed when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_sync_fifo
    import io_map_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [IO_WORD_W-1:0] wdata,
    output logic [IO_WORD_W-1:0] rdata,
    output logic                 empty,
    output logic                 full
);

    logic [IO_WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]) &&
                   (r_wr_ptr[PTR_W-1]   != r_rd_ptr[PTR_W-1]);

    // A push while full is legal only when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign rdata = empty ? '0 : r_mem[r_rd_ptr[PTR_W-2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-2:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_io_bridge.sv
// ============================================================================
//  Module      : mmio_io_bridge
//  Description : CPU store-mapped output FIFO and input holding register.
//                Optional IO_STALL_EN: stall the CPU instead of dropping on full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_io_bridge
    import io_map_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 memw,
    input  logic [15:0]          addr_in,
    input  logic [IO_WORD_W-1:0] dataw_in,
    output logic [IO_WORD_W-1:0] dp_input,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IO_WORD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IO_WORD_W-1:0] out_data,
    output logic                 overflow,
    output logic                 stall
);

    logic                 w_push;
    logic                 w_pop;
    logic                 w_ack;
    logic                 w_empty;
    logic                 w_full;
    logic                 r_in_full;
    logic [IO_WORD_W-1:0] r_in_reg;

    assign w_push = memw && (addr_in == IO_OUT_ADDR);
    assign w_ack  = memw && (addr_in == IO_ACK_ADDR);
    assign w_pop  = out_valid && out_ready;

    io_sync_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (dataw_in),
        .rdata (out_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign out_valid = !w_empty;

`ifdef IO_STALL_EN
    // The CPU holds the store while stalled, so nothing is ever lost.
    assign stall    = w_push && w_full && !w_pop;
    assign overflow = 1'b0;
`else
    logic r_overflow;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign stall    = 1'b0;
    assign overflow = r_overflow;
`endif

    // A load only happens when empty, so an ack on a full register never reloads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_full <= 1'b0;
            r_in_reg  <= '0;
        end else if (in_valid && !r_in_full) begin
            r_in_full <= 1'b1;
            r_in_reg  <= in_data;
        end else if (w_ack) begin
            r_in_full <= 1'b0;
        end
    end

    assign in_ready = !r_in_full;
    assign dp_input = r_in_full ? r_in_reg : '0;

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_bridge.sv
// ============================================================================
//  Module      : tb_mmio_io_bridge
//  Description : Directed plus random stimulus against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_bridge;

    localparam int          c_depth = 4;
    localparam logic [15:0] c_out   = 16'h3FFC;
    localparam logic [15:0] c_in    = 16'h3FFE;
    localparam logic [15:0] c_ack   = 16'h3FFA;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        memw = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] dataw_in = '0;
    logic [15:0] dp_input;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        overflow;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_in_full = 1'b0;
    logic [15:0] m_in_word = '0;

    mmio_io_bridge #(.DEPTH(c_depth)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .memw      (memw),
        .addr_in   (addr_in),
        .dataw_in  (dataw_in),
        .dp_input  (dp_input),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .stall     (stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare every output to the model, advance both.
    task automatic step(input logic m, input logic [15:0] a, input logic [15:0] d,
                        input logic iv, input logic [15:0] id, input logic ordy,
                        input logic r);
        logic        e_valid, e_stall, push, pop, ack, was_full;
        logic [15:0] e_data;
        memw = m; addr_in = a; dataw_in = d;
        in_valid = iv; in_data = id; out_ready = ordy; RST = r;
        #1;
        e_valid  = (m_q.size() != 0);
        e_data   = e_valid ? m_q[0] : 16'h0000;
        push     = m && (a == c_out);
        ack      = m && (a == c_ack);
        pop      = e_valid && ordy;
        was_full = (m_q.size() == c_depth);
`ifdef IO_STALL_EN
        e_stall = push && was_full && !pop;
`else
        e_stall = 1'b0;
`endif
        check("out_valid", {15'b0, out_valid}, {15'b0, e_valid});
        check("out_data",  out_data, e_data);
        check("in_ready",  {15'b0, in_ready}, {15'b0, !m_in_full});
        check("dp_input",  dp_input, m_in_full ? m_in_word : 16'h0000);
        check("overflow",  {15'b0, overflow}, {15'b0, m_ovf});
        check("stall",     {15'b0, stall}, {15'b0, e_stall});
        @(posedge CLK);
        if (r) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_in_full = 1'b0;
            m_in_word = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (!was_full || pop) m_q.push_back(d);
`ifndef IO_STALL_EN
                else m_ovf = 1'b1;
`endif
            end
            if (iv && !m_in_full) begin
                m_in_full = 1'b1;
                m_in_word = id;
            end else if (ack) begin
                m_in_full = 1'b0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, ordy, 1'b0);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic ordy);
        step(1'b1, a, d, 1'b0, 16'h0000, ordy, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        @(negedge CLK);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("rst_in_ready", {15'b0, in_ready}, 16'h0001);
        check("rst_out_valid", {15'b0, out_valid}, 16'h0000);

        // Ordered drain
        store(c_out, 16'h0011, 1'b0);
        store(c_out, 16'h0022, 1'b0);
        store(c_out, 16'h0033, 1'b0);
        check("t1_valid", {15'b0, out_valid}, 16'h0001);
        check("t1_head", out_data, 16'h0011);
        idle(1'b1);
        check("t1_second", out_data, 16'h0022);
        idle(1'b1);
        check("t1_third", out_data, 16'h0033);
        idle(1'b1);
        check("t1_empty", {15'b0, out_valid}, 16'h0000);

        // Overflow or stall on full
        for (int i = 0; i < c_depth; i++) store(c_out, 16'h0100 + 16'(i), 1'b0);
        store(c_out, 16'hBEEF, 1'b0);
`ifdef IO_STALL_EN
        store(c_out, 16'hBEEF, 1'b1);
        check("t2_overflow", {15'b0, overflow}, 16'h0000);
`else
        check("t2_overflow", {15'b0, overflow}, 16'h0001);
`endif
        for (int i = 0; i < c_depth + 1; i++) idle(1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Push and pop together while full
        for (int i = 0; i < c_depth; i++) store(c_out, 16'h0200 + 16'(i), 1'b0);
        store(c_out, 16'h5555, 1'b1);
        check("t3_overflow", {15'b0, overflow}, 16'h0000);
        for (int i = 0; i < c_depth - 1; i++) idle(1'b1);
        check("t3_last", out_data, 16'h5555);
        idle(1'b1);

        // Input holding register
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0);
        check("t4_dp", dp_input, 16'hA5A5);
        check("t4_ready", {15'b0, in_ready}, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
        check("t4_hold", dp_input, 16'hA5A5);
        step(1'b1, c_ack, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
        check("t4_ack", dp_input, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
        check("t4_reload", dp_input, 16'h1234);
        store(c_ack, 16'h0000, 1'b0);

        // Stores that touch nothing
        store(c_in, 16'h7777, 1'b0);
        store(c_ack, 16'h8888, 1'b0);
        check("t5_valid", {15'b0, out_valid}, 16'h0000);
        check("t5_dp", dp_input, 16'h0000);

        // Reset mid-transfer
        store(c_out, 16'h0AAA, 1'b0);
        step(1'b1, c_out, 16'h0BBB, 1'b1, 16'h0CCC, 1'b0, 1'b0);
        step(1'b1, c_out, 16'h0DDD, 1'b1, 16'h0EEE, 1'b1, 1'b1);
        check("t6_valid", {15'b0, out_valid}, 16'h0000);
        check("t6_data", out_data, 16'h0000);
        check("t6_ready", {15'b0, in_ready}, 16'h0001);
        check("t6_dp", dp_input, 16'h0000);
        check("t6_ovf", {15'b0, overflow}, 16'h0000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = c_out;
                2:       a = c_ack;
                default: a = ($urandom_range(0, 1) != 0) ? c_in : 16'($urandom);
            endcase
            step(($urandom_range(0, 1) != 0), a, 16'($urandom),
                 ($urandom_range(0, 2) == 0), 16'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
